// File: rtl/servo_pwm_driver_if.sv
// servo_pwm_driver_if
// Groups the servo driver's control inputs and status outputs into one bundle.
//   en          : output enable (low forces both PWM lines low)
//   x_val/y_val : pan/tilt targets, unsigned 0..2047
//   pwm_x/pwm_y : registered servo PWM outputs
//   frame_start : one-cycle strobe, high while the frame counter is 0
//   x_applied/y_applied : slew-limited values currently driving the PWM
// Modports: master drives the targets and enable, slave is the driver itself.
interface servo_pwm_driver_if;
  logic        en;
  logic [10:0] x_val;
  logic [10:0] y_val;
  logic        pwm_x;
  logic        pwm_y;
  logic        frame_start;
  logic [10:0] x_applied;
  logic [10:0] y_applied;

  modport master (
    output en, x_val, y_val,
    input  pwm_x, pwm_y, frame_start, x_applied, y_applied
  );

  modport slave (
    input  en, x_val, y_val,
    output pwm_x, pwm_y, frame_start, x_applied, y_applied
  );
endinterface

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
// Converts two 11-bit steering values into hobby-servo PWM for pan (x) and
// tilt (y). Targets are sampled once per frame at the counter wrap, pass
// through a per-frame slew limiter, and are mapped linearly to a clamped
// pulse width.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : servo_pwm_driver_if.slave (en, x_val, y_val in; pwm_x, pwm_y,
//         frame_start, x_applied, y_applied out)
// Handshake: none; targets are level inputs sampled only on the wrap edge
// (cnt == FRAME_CYCLES-1 -> 0). A value presented on that very edge is used.
module servo_pwm_driver #(
  parameter int FRAME_CYCLES = 2_000_000,
  parameter int MIN_PULSE    = 100_000,
  parameter int SCALE        = 49,
  parameter int MAX_PULSE    = 200_000,
  parameter int MAX_STEP     = 64,
  parameter int CENTER       = 1024
) (
  input logic               clk,
  input logic               rst,
  servo_pwm_driver_if.slave bus
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int SW = $clog2(SCALE + 1);
  localparam int PW = 11 + SW;
  localparam logic signed [11:0] STEP_S = 12'(MAX_STEP);
  localparam logic [10:0]        STEP_U = 11'(MAX_STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   x_app_q, x_app_d;
  logic [10:0]   y_app_q, y_app_d;
  logic          pwm_x_q, pwm_x_d;
  logic          pwm_y_q, pwm_y_d;
  logic          fs_q, fs_d;
  logic          wrap;
  logic [31:0]   width_x, width_y;

  // Move cur toward tgt by at most MAX_STEP; the clamped step can never
  // overshoot the target, so the result stays inside 0..2047.
  function automatic logic [10:0] slew(input logic [10:0] tgt,
                                       input logic [10:0] cur);
    logic signed [11:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       return cur + STEP_U;
    else if (diff < -STEP_S) return cur - STEP_U;
    else                     return tgt;
  endfunction

  // Full-precision product, then saturate at MAX_PULSE.
  function automatic logic [31:0] pulse_width(input logic [10:0] a);
    logic [PW-1:0] prod;
    logic [31:0]   w;
    prod = {{SW{1'b0}}, a} * PW'(SCALE);
    w    = 32'(MIN_PULSE) + 32'(prod);
    return (w > 32'(MAX_PULSE)) ? 32'(MAX_PULSE) : w;
  endfunction

  always_comb begin
    width_x = pulse_width(x_app_q);
    width_y = pulse_width(y_app_q);
  end

  always_comb begin
    wrap    = 1'b0;
    cnt_d   = cnt_q;
    x_app_d = x_app_q;
    y_app_d = y_app_q;
    pwm_x_d = 1'b0;
    pwm_y_d = 1'b0;
    fs_d    = 1'b0;

    wrap  = (cnt_q == CW'(FRAME_CYCLES - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap) begin
      x_app_d = slew(bus.x_val, x_app_q);
      y_app_d = slew(bus.y_val, y_app_q);
    end
    // Registered compare against the current count: the pulse lags cnt by
    // one cycle and is high for exactly width cycles.
    pwm_x_d = bus.en && (32'(cnt_q) < width_x);
    pwm_y_d = bus.en && (32'(cnt_q) < width_y);
    // Registered wrap flag lines up with cnt == 0.
    fs_d    = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      x_app_q <= 11'(CENTER);
      y_app_q <= 11'(CENTER);
      pwm_x_q <= 1'b0;
      pwm_y_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      x_app_q <= x_app_d;
      y_app_q <= y_app_d;
      pwm_x_q <= pwm_x_d;
      pwm_y_q <= pwm_y_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.pwm_x       = pwm_x_q;
  assign bus.pwm_y       = pwm_y_q;
  assign bus.frame_start = fs_q;
  assign bus.x_applied   = x_app_q;
  assign bus.y_applied   = y_app_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver with a shortened frame (4096 cycles),
// 1000..3000 cycle pulses and unit scale.
module tb_servo_pwm_driver;

  localparam int FC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_pwm_driver_if bus ();

  servo_pwm_driver #(
    .FRAME_CYCLES(FC),
    .MIN_PULSE   (1000),
    .SCALE       (1),
    .MAX_PULSE   (3000),
    .MAX_STEP    (64),
    .CENTER      (1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {x_applied, y_applied, width_x, width_y}
  logic [45:0] exp_q[$];

  // Reference model state: applied values for the current frame and the
  // targets currently driven.
  int m_ax = 1024;
  int m_ay = 1024;
  int m_tx = 0;
  int m_ty = 0;

  function automatic int model_slew(input int a, input int t);
    if (t - a > 64)       return a + 64;
    else if (t - a < -64) return a - 64;
    else                  return t;
  endfunction

  function automatic int model_width(input int a, input int en_v);
    int w;
    w = 1000 + a;
    if (w > 3000) w = 3000;
    return (en_v != 0) ? w : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one full frame starting at a negedge where cnt == 0. Targets nx/ny
  // are driven at entry (they take effect at the wrap ending this frame);
  // if act_cyc >= 0, x_val is changed to act_x mid-frame.
  task automatic do_frame(input int en_v, input int nx, input int ny,
                          input int act_cyc, input int act_x);
    logic [45:0] e;
    int hx, hy, fs_cnt;
    exp_q.push_back({11'(m_ax), 11'(m_ay),
                     12'(model_width(m_ax, en_v)), 12'(model_width(m_ay, en_v))});
    bus.en    = (en_v != 0);
    bus.x_val = 11'(nx);
    bus.y_val = 11'(ny);
    m_tx = nx;
    m_ty = ny;
    check("x_applied", 32'(bus.x_applied), 32'(exp_q[0][45:35]));
    check("y_applied", 32'(bus.y_applied), 32'(exp_q[0][34:24]));
    hx = 0; hy = 0; fs_cnt = 0;
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      if (bus.pwm_x) hx++;
      if (bus.pwm_y) hy++;
      if (bus.frame_start) fs_cnt++;
      if (i == act_cyc) begin
        bus.x_val = 11'(act_x);
        m_tx = act_x;
      end
    end
    m_ax = model_slew(m_ax, m_tx);
    m_ay = model_slew(m_ay, m_ty);
    e = exp_q.pop_front();
    check("width_x", 32'(hx), 32'(e[23:12]));
    check("width_y", 32'(hy), 32'(e[11:0]));
    check("frame_start_count", 32'(fs_cnt), 32'd1);
    check("frame_start_at_wrap", 32'(bus.frame_start), 32'd1);
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.x_val = 11'd0;
    bus.y_val = 11'd0;

    // Reset defaults, checked while reset is held.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_pwm_x", 32'(bus.pwm_x), 32'd0);
      check("rst_pwm_y", 32'(bus.pwm_y), 32'd0);
      check("rst_frame_start", 32'(bus.frame_start), 32'd0);
      check("rst_x_applied", 32'(bus.x_applied), 32'd1024);
      check("rst_y_applied", 32'(bus.y_applied), 32'd1024);
    end
    rst = 1'b0;

    // Frame 0 runs at CENTER; x ramps up to 2047 while y ramps down to 0.
    // Frames 1..3 have en low: no pulses, but slewing and strobes continue.
    do_frame(1, 2047, 0, -1, 0);
    for (int f = 1; f < 16; f++) begin
      do_frame((f >= 4) ? 1 : 0, 2047, 0, -1, 0);
      if (f == 1) check("x_ramp_first_step", 32'(bus.x_applied), 32'd1152);
    end
    check("x_reaches_top", 32'(bus.x_applied), 32'd2047);
    check("y_reaches_bottom", 32'(bus.y_applied), 32'd0);

    // Frame 16: x saturates at 3000 cycles, y at 1000; y target becomes 30.
    do_frame(1, 2047, 30, -1, 0);
    check("y_small_step", 32'(bus.y_applied), 32'd30);

    // Mid-frame target changes only matter if still present at the wrap.
    do_frame(1, 2047, 30, 500, 1024);
    check("x_after_midframe_drop", 32'(bus.x_applied), 32'd1983);
    do_frame(1, 1024, 30, 500, 2047);

    // Reset in the middle of an x pulse.
    check("pre_rst_x_applied", 32'(bus.x_applied), 32'(m_ax));
    repeat (1500) @(negedge clk);
    check("pre_rst_pwm_x_high", 32'(bus.pwm_x), 32'd1);
    check("pre_rst_pwm_y_low", 32'(bus.pwm_y), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm_x", 32'(bus.pwm_x), 32'd0);
    check("midrst_x_applied", 32'(bus.x_applied), 32'd1024);
    check("midrst_y_applied", 32'(bus.y_applied), 32'd1024);
    check("midrst_frame_start", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;
    m_ax = 1024;
    m_ay = 1024;
    do_frame(1, 1024, 1024, -1, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
# servo_pwm_driver

Downstream stage of the backtrack block: converts the two 11-bit steering values (x_val_out / y_val_out) into two standard hobby-servo PWM signals for the pan (x) and tilt (y) servos on the Basys3 Pmod header. Inputs are sampled once per 20 ms frame. A per-frame slew limiter smooths joystick jumps and the step reversals produced when backtrack engages. Each sample is then mapped linearly to a clamped pulse width.

## Interface

Parameters:
- FRAME_CYCLES, 2_000_000, PWM period in clk cycles (20 ms at 100 MHz)
- MIN_PULSE, 100_000, pulse width in cycles for value 0 (1.0 ms)
- SCALE, 49, cycles added per value LSB
- MAX_PULSE, 200_000, upper clamp on pulse width (2.0 ms); must be < FRAME_CYCLES
- MAX_STEP, 64, max change of applied value per frame (1..2047)
- CENTER, 1024, reset value of applied x/y

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset; synchronous, active-high
- en  in  1  output enable; low forces both PWM lines low
- x_val  in  11  target pan value, unsigned 0..2047
- y_val  in  11  target tilt value, unsigned 0..2047
- pwm_x  out  1  pan servo PWM, registered
- pwm_y  out  1  tilt servo PWM, registered
- frame_start  out  1  one-cycle strobe, high during the cycle cnt==0
- x_applied  out  11  value currently driving pwm_x
- y_applied  out  11  value currently driving pwm_y

## Operation

- Frame counter cnt, width $clog2(FRAME_CYCLES), counts 0..FRAME_CYCLES-1 and then wraps to 0.
- Input sampling:
  - x_val/y_val are sampled only at the edge where cnt wraps (FRAME_CYCLES-1 → 0).
  - Changes at any other time have no effect on the current frame.
- Slew limiter, per axis, evaluated at the wrap edge:
  - diff = target − applied, 12-bit signed.
  - diff > MAX_STEP: applied += MAX_STEP.
  - diff < −MAX_STEP: applied −= MAX_STEP.
  - Otherwise applied = target.
  - Result always lies in 0..2047; no wrap is possible.
- Width, per axis, combinational from the applied value:
  - width = MIN_PULSE + applied*SCALE, computed without truncation (product width 11+$clog2(SCALE+1)).
  - If the result exceeds MAX_PULSE, width = MAX_PULSE.
- PWM: each clock edge, pwm ← en && (cnt < width), using the current cnt and width.
- en affects only the pwm lines. Counter, sampling and slew keep running while en is low.
- frame_start ← (cnt == FRAME_CYCLES-1), so it is high exactly while cnt==0.

## Timing

- Reset values:
  - cnt=0
  - x_applied = y_applied = CENTER
  - pwm_x = pwm_y = 0
  - frame_start = 0
- First frame after reset:
  - Uses CENTER, not x_val/y_val.
  - pwm rises at the first edge after rst deasserts.
  - First frame_start occurs FRAME_CYCLES cycles after reset release.
- Pulse timing:
  - Each pulse is high for exactly width cycles.
  - It lags cnt by one cycle: it rises at the edge leaving cnt==0 and falls at the edge leaving cnt==width.
- Latency from an input change to its effect on PWM:
  - The value is applied at the next wrap edge.
  - The pulse reflecting it starts one cycle later.
- Full-scale traversal takes ceil(|Δ|/MAX_STEP) frames, e.g. 16 frames for 1024 → 2047 at MAX_STEP=64.
- Reset mid-frame:
  - Next edge restores all reset values.
  - An in-progress pulse is cut immediately, with no runt completion.
- en deasserted mid-pulse: pwm falls at the next edge.
- en asserted mid-frame: pwm goes high at the next edge if cnt < width. Partial pulses are permitted.
- x_val change on the same edge as the wrap: the new value is the one sampled.

## Test plan

Bench overrides: FRAME_CYCLES=4096, MIN_PULSE=1000, SCALE=1, MAX_PULSE=3000, MAX_STEP=64.

- **Reset defaults:** rst 3 cycles, x_val=y_val=0 → all outputs 0, x_applied=y_applied=1024 during reset; first frame pulses are 2024 cycles; frame_start first high 4096 cycles after release.
- **Slew up and clamp:** x_val=2047 held → x_applied reads 1088, 1152, … per frame; reaches 2047 on frame 16; pulse width saturates at 3000 (not 3047).
- **Slew down and small steps:**
  - x_val=0 from 1024 → reaches 0 after 16 frames; pulse width 1000.
  - Then x_val=30 → applied=30 in one frame; width 1030.
- **Mid-frame input change:** x_val toggles 1024↔2047 at cnt=500 within one frame → current frame pulse unchanged; only the value present at the wrap edge is used.
- **Enable gating:** en=0 for 3 frames with x_val=2047 → pwm_x/pwm_y stay 0; x_applied still ramps 1088/1152/1216; frame_start keeps pulsing every 4096 cycles.
- **Reset mid-pulse:** assert rst at cnt=1500 with width 2024 → pwm falls next edge, cnt=0, applied=1024; the following frame produces a full 2024-cycle pulse.
